// File: rtl/medac_pkg.sv
// medac_pkg: FSM state codes and width helpers shared by
// the MEDAC adaptive-delay controller.
package medac_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OBSERVE = 2'd1;
    localparam logic [1:0] ST_DECIDE  = 2'd2;
    localparam logic [1:0] ST_SETTLE  = 2'd3;

    // Readout index is one bit wider than needed so "no channel" is encodable.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/medac_err_cnt.sv
// medac_err_cnt: saturating up-counter with synchronous
// clear and increment enable.
module medac_err_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/medac_adapt.sv
// medac_adapt: windowed multi-phase error counting that steps
// the variable-delay clock code up, down or holds it.
module medac_adapt
    import medac_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 12,
    parameter int SEL_W      = 4,
    parameter int SEL_MAX    = 2**SEL_W-1,
    parameter int SETTLE_CYC = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   mode,
    input  logic [WIN_W-1:0]       win_len,
    input  logic [CNT_W-1:0]       thresh,
    input  logic [SEL_W-1:0]       sel_init,
    input  logic [N_CH-1:0]        err,
    input  logic [idx_w(N_CH)-1:0] rd_idx,
    output logic [SEL_W-1:0]       sel,
    output logic                   win_done,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       win_num
);

    localparam int IDX_W = idx_w(N_CH);
    localparam int TMR_W = max_w(WIN_W, $clog2(SETTLE_CYC) + 1);
    localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(SEL_MAX);
    localparam logic [TMR_W-1:0] SET_END = TMR_W'(SETTLE_CYC - 1);

    logic [1:0]       r_state;
    logic [WIN_W-1:0] r_len;
    logic [TMR_W-1:0] r_tmr;
    logic [SEL_W-1:0] r_sel;
    logic             r_win_done;
    logic [CNT_W-1:0] r_snap [N_CH];
    logic [CNT_W-1:0] r_rd_cnt;

    logic [CNT_W-1:0] w_cnt [N_CH];
    logic [CNT_W-1:0] w_rd;
    logic [WIN_W-1:0] w_len;
    logic [SEL_W-1:0] w_sel_nxt;
    logic             w_obs;
    logic             w_dec;
    logic             w_clr;
    logic             w_win_end;
    logic             w_guard_ok;

    assign w_len     = (win_len == '0) ? WIN_W'(1) : win_len;
    assign w_obs     = en && (r_state == ST_OBSERVE);
    assign w_dec     = en && (r_state == ST_DECIDE);
    assign w_clr     = (r_state != ST_OBSERVE);
    assign w_win_end = (r_tmr == (TMR_W'(r_len) - TMR_W'(1)));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        medac_err_cnt #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (w_clr),
            .i_inc (w_obs && err[g]),
            .o_cnt (w_cnt[g])
        );
    end

    medac_err_cnt #(.W(CNT_W)) u_win (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (1'b0),
        .i_inc (w_dec),
        .o_cnt (win_num)
    );

    // Origin failing pushes the code up; only a clean guard band pulls it down.
    always_comb begin
        w_guard_ok = 1'b1;
        for (int i = 1; i < N_CH; i++) begin
            if (w_cnt[i] > thresh) w_guard_ok = 1'b0;
        end
        w_sel_nxt = r_sel;
        if (!mode) begin
            w_sel_nxt = sel_init;
        end else if (w_cnt[0] > thresh) begin
            if (r_sel < SEL_TOP) w_sel_nxt = r_sel + SEL_W'(1);
        end else if (w_guard_ok) begin
            if (r_sel != '0) w_sel_nxt = r_sel - SEL_W'(1);
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_idx == IDX_W'(i)) w_rd = r_snap[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= WIN_W'(1);
            r_tmr      <= '0;
            r_sel      <= '0;
            r_win_done <= 1'b0;
        end else begin
            r_win_done <= w_dec;
            if (!en) begin
                r_state <= ST_IDLE;
                r_tmr   <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_sel   <= sel_init;
                        r_len   <= w_len;
                        r_tmr   <= '0;
                        r_state <= ST_OBSERVE;
                    end
                    ST_OBSERVE: begin
                        if (w_win_end) begin
                            r_tmr   <= '0;
                            r_state <= ST_DECIDE;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    ST_DECIDE: begin
                        r_sel   <= w_sel_nxt;
                        r_tmr   <= '0;
                        r_state <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (r_tmr == SET_END) begin
                            r_len   <= w_len;
                            r_tmr   <= '0;
                            r_state <= ST_OBSERVE;
                        end else begin
                            r_tmr <= r_tmr + TMR_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) r_snap[i] <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_dec) begin
                for (int i = 0; i < N_CH; i++) r_snap[i] <= w_cnt[i];
            end
            r_rd_cnt <= w_rd;
        end
    end

    assign sel      = r_sel;
    assign win_done = r_win_done;
    assign rd_cnt   = r_rd_cnt;

endmodule

// File: tb/tb_medac_adapt.sv
// tb_medac_adapt: randomized windows checked against a
// window-level model of the MEDAC decision rules.
module tb_medac_adapt;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        mode     = 1'b1;
    logic [11:0] win_len  = 12'd10;
    logic [7:0]  thresh   = 8'd2;
    logic [3:0]  sel_init = 4'd0;
    logic [2:0]  err      = 3'd0;
    logic [2:0]  rd_idx   = 3'd0;
    logic [3:0]  sel;
    logic        win_done;
    logic [7:0]  rd_cnt;
    logic [7:0]  win_num;

    int n_tests = 0;
    int n_fail  = 0;
    int msel, msi, mwn, mlen;
    int msnap [3];

    always #5 clk = ~clk;

    medac_adapt #(
        .N_CH       (3),
        .CNT_W      (8),
        .WIN_W      (12),
        .SEL_W      (4),
        .SETTLE_CYC (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .win_len  (win_len),
        .thresh   (thresh),
        .sel_init (sel_init),
        .err      (err),
        .rd_idx   (rd_idx),
        .sel      (sel),
        .win_done (win_done),
        .rd_cnt   (rd_cnt),
        .win_num  (win_num)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int decide(input int s, input int c0, input int c1,
                                  input int c2, input int th, input bit md);
        if (!md) return msi;
        if (c0 > th) return (s < 15) ? s + 1 : 15;
        if (c1 <= th && c2 <= th) return (s > 0) ? s - 1 : 0;
        return s;
    endfunction

    task automatic start(input int si, input int wl);
        @(negedge clk);
        sel_init = 4'(si);
        win_len  = 12'(wl);
        en       = 1'b1;
        err      = 3'($urandom);
        msi  = si;
        msel = si;
        mlen = (wl == 0) ? 1 : wl;
    endtask

    task automatic stop();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("sel_idle", 32'(sel), msel);
        check("wd_idle", 32'(win_done), 0);
    endtask

    task automatic window(input int p0, input int p1, input int p2,
                          input int th, input bit md, input int nwl,
                          input bit drop);
        int c [3];
        int pr [3];
        int idx;
        int exp_rd;
        logic [2:0] e;
        c  = '{0, 0, 0};
        pr = '{p0, p1, p2};
        for (int k = 0; k < mlen; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("sel_obs", 32'(sel), msel);
                win_len = 12'($urandom);
                thresh  = 8'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                e[i] = ($urandom_range(99) < pr[i]);
                if (e[i]) c[i]++;
            end
            err = e;
        end
        @(negedge clk);
        check("wd_dec", 32'(win_done), 0);
        check("sel_dec", 32'(sel), msel);
        thresh = 8'(th);
        mode   = md;
        err    = 3'($urandom);
        if (drop) en = 1'b0;
        @(negedge clk);
        if (drop) begin
            check("wd_drop", 32'(win_done), 0);
            check("sel_drop", 32'(sel), msel);
            check("wn_drop", 32'(win_num), mwn);
            idx    = $urandom_range(7);
            rd_idx = 3'(idx);
            @(negedge clk);
            exp_rd = (idx < 3) ? msnap[idx] : 0;
            check("rd_drop", 32'(rd_cnt), exp_rd);
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (c[i] > 255) c[i] = 255;
            msnap[i] = c[i];
        end
        msel = decide(msel, c[0], c[1], c[2], th, md);
        if (mwn < 255) mwn++;
        check("sel", 32'(sel), msel);
        check("wd", 32'(win_done), 1);
        check("win_num", 32'(win_num), mwn);
        idx    = $urandom_range(7);
        rd_idx = 3'(idx);
        err    = 3'($urandom);
        @(negedge clk);
        exp_rd = (idx < 3) ? msnap[idx] : 0;
        check("rd_cnt", 32'(rd_cnt), exp_rd);
        check("wd_s1", 32'(win_done), 0);
        for (int s = 2; s < 8; s++) begin
            @(negedge clk);
            err = 3'($urandom);
            if (s == 2) win_len = 12'(nwl);
        end
        mlen = (nwl == 0) ? 1 : nwl;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nw;
        bit dr;
        msel = 0; msi = 0; mwn = 0; mlen = 1;
        msnap = '{0, 0, 0};
        #1;
        check("rst_sel", 32'(sel), 0);
        check("rst_wd", 32'(win_done), 0);
        check("rst_rd", 32'(rd_cnt), 0);
        check("rst_wn", 32'(win_num), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_sel", 32'(sel), 0);

        start(5, 10);
        window(30, 0, 0, 2, 1'b1, 10, 1'b0);
        window(0, 0, 0, 2, 1'b1, 10, 1'b0);

        @(negedge clk);
        err = 3'b111;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", 32'(sel), 0);
        check("mid_rst_wd", 32'(win_done), 0);
        check("mid_rst_rd", 32'(rd_cnt), 0);
        check("mid_rst_wn", 32'(win_num), 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        msel = 0; mwn = 0;
        msnap = '{0, 0, 0};
        rd_idx = 3'd0;
        repeat (2) @(negedge clk);
        check("post_rst_sel", 32'(sel), 0);
        check("post_rst_wd", 32'(win_done), 0);
        check("post_rst_rd", 32'(rd_cnt), 0);

        start(5, 10);  window(0, 0, 0, 2, 1'b1, 10, 1'b0);     stop();
        start(0, 10);  window(0, 0, 0, 2, 1'b1, 10, 1'b0);     stop();
        start(5, 10);  window(0, 0, 50, 2, 1'b1, 10, 1'b0);    stop();
        start(15, 300); window(100, 0, 0, 2, 1'b1, 10, 1'b0);  stop();
        start(7, 10);  window(60, 60, 60, 2, 1'b0, 10, 1'b0);  stop();
        start(9, 10);
        window(40, 20, 20, 2, 1'b1, 10, 1'b0);
        window(40, 20, 20, 2, 1'b1, 10, 1'b1);
        stop();

        for (int r = 0; r < 120; r++) begin
            start($urandom_range(15), $urandom_range(16));
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                dr = (w == nw - 1) && ($urandom_range(3) == 0);
                window($urandom_range(60), $urandom_range(60),
                       $urandom_range(60), $urandom_range(6),
                       ($urandom_range(7) != 0), $urandom_range(16), dr);
            end
            stop();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/medac_adapt.md
# medac_adapt

Parametrised adaptive-delay controller for the metastability-error-detection adaptive clocking (MEDAC) path. It accepts `N_CH` error flags from metastability detectors placed at staggered clock phases, and counts errors per channel over a programmable observation window. At the end of each window it steps a delay code up, down or holds it, then waits a settle period before observing again. It replaces the single-bit origin/leading selector, adding a multi-phase guard band, a windowed decision, hysteresis by threshold, and per-channel statistics readout.

## Interface
- `N_CH`, 3: error channels; ch0 = origin phase (clock in use), ch1..N_CH-1 = progressively leading guard phases
- `CNT_W`, 16: per-channel error counter width (saturating)
- `WIN_W`, 12: window-length field width
- `SEL_W`, 4: delay code width
- `SEL_MAX`, 2**SEL_W-1: upper bound of delay code
- `SETTLE_CYC`, 8: cycles ignored after each code change (≥1)
- `clk`  in  1  controller clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `en`  in  1  1 = run; 0 = return to IDLE
- `mode`  in  1  1 = adaptive (code updates); 0 = fixed code `sel_init`, statistics still gathered
- `win_len`  in  WIN_W  window length in cycles; 0 treated as 1
- `thresh`  in  CNT_W  error-count threshold
- `sel_init`  in  SEL_W  starting/fixed delay code
- `err`  in  N_CH  detector error flags, already synchronous to `clk`
- `rd_idx`  in  clog2(N_CH)+1  snapshot channel select
- `sel`  out  SEL_W  delay code to the variable-delay clock line
- `win_done`  out  1  one-cycle pulse when a window's decision takes effect
- `rd_cnt`  out  CNT_W  registered snapshot count of channel `rd_idx`
- `win_num`  out  CNT_W  completed-window count, saturating

## Operation
- States: IDLE, OBSERVE, DECIDE, SETTLE.
- IDLE: counters cleared; `sel` holds its value. On `en`=1: load `sel`←`sel_init`, latch `win_len`, go to OBSERVE.
- OBSERVE: each cycle, `cnt[i]` += `err[i]`, saturating at 2^CNT_W−1. Lasts exactly max(latched `win_len`,1) cycles, then goes to DECIDE. Changes to `win_len` take effect at the next window start.
- DECIDE (1 cycle): sample `thresh`; copy all `cnt[i]` to snapshot regs; `win_num`++ (saturating). With `mode`=1:
  - `cnt[0]` > `thresh` → `sel`+1, saturating at `SEL_MAX`.
  - Else, if every `cnt[1..N_CH-1]` ≤ `thresh` → `sel`−1, saturating at 0.
  - Else → hold.
  - With `mode`=0, `sel`←`sel_init`.
  - Next state is SETTLE.
- SETTLE: counters cleared; `err` ignored for `SETTLE_CYC` cycles. Then re-latch `win_len` and go to OBSERVE.
- `en`=0 in any state → IDLE on the next edge. This takes priority over DECIDE: no `sel` change, no snapshot, no `win_done`.
- `rd_cnt` = snapshot[`rd_idx`], registered; `rd_idx` ≥ N_CH → 0.

## Timing
- Reset values: `sel`=0, `win_done`=0, `rd_cnt`=0, `win_num`=0, snapshots=0, state IDLE. Reset mid-window discards the window.
- First OBSERVE cycle is the cycle after `en` is sampled high in IDLE.
- The `err` sampled on OBSERVE cycle k counts toward that window. An `err` sampled in DECIDE/SETTLE is dropped.
- The new `sel` and `win_done`=1 appear together on the first SETTLE cycle (one edge after DECIDE).
- Window period = max(win_len,1) + 1 + SETTLE_CYC cycles.
- `rd_cnt` latency is 1 cycle from `rd_idx` or snapshot update.
- When `err[i]`=1 and a counter is saturated, the counter holds; there is no wrap.

## Structure
- Package `medac_pkg`: state enum (IDLE/OBSERVE/DECIDE/SETTLE) and the `$clog2`-based width helpers.
- Sub-module `medac_err_cnt`: CNT_W saturating counter with synchronous clear and increment enable. Instantiate it `N_CH` times, and once more for `win_num`.
- Top holds the FSM, window/settle counter, decision logic, snapshot regs and readout mux.

## Test plan
All scenarios use N_CH=3, CNT_W=8, SETTLE_CYC=8, win_len=10, thresh=2.
- Reset: assert `rst_n`=0 mid-OBSERVE → all outputs 0 immediately. Release with `en`=0 → state IDLE, `sel`=0.
- Origin failing: `sel_init`=5, `err[0]` high on 3 of 10 cycles → `sel`=6 with `win_done` pulse; `rd_idx`=0 → `rd_cnt`=3; `win_num`=1.
- Clean margin: all `err`=0 for a window → `sel` 5→4. Repeating from `sel`=0 → `sel` stays 0.
- Guard hit: `err[0]`=0, `err[2]` high for 5 cycles → `sel` holds 5; `rd_idx`=2 → 5; `rd_idx`=3 → 0.
- Saturation: `win_len`=300, `err[0]` constant high, `sel_init`=15 → snapshot 255, `sel` stays 15.
- Control: `mode`=0 with errors → `sel` stays `sel_init` and `win_done` still pulses. `en` drops on the DECIDE cycle → IDLE, no pulse, `sel` unchanged.
